image_ram_arbiter: RTL and testbench
====================================

// Module: image_ram_arbiter
// PURPOSE
//  Shares the single-port synchronous image RAM between two requesters:
//   - the CPU data port (read/write)
//   - the display scanout engine (read-only)
//  Sits between the processor memory-select path and the image RAM.
//  Display has priority; a wait counter bounds CPU starvation.
//  One access is in flight at a time.
// PARAMETERS
//  ADDR_W    16  RAM word-address width
//  DATA_W    32  RAM data width
//  MAX_WAIT  4   consecutive display grants allowed while cpu_req pending (>=1)
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       asynchronous, active-low
//  cpu_req     in   1       CPU request; held with addr/we/wdata until cpu_ack
//  cpu_we      in   1       1 = write, 0 = read
//  cpu_addr    in   ADDR_W  CPU word address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_ack     out  1       1-cycle completion pulse
//  cpu_rdata   out  DATA_W  read data, valid only while cpu_ack=1 on a read
//  disp_req    in   1       display read request; held with disp_addr until disp_valid
//  disp_addr   in   ADDR_W  display word address
//  disp_valid  out  1       1-cycle completion pulse
//  disp_rdata  out  DATA_W  read data, valid only while disp_valid=1
//  ram_addr    out  ADDR_W  registered RAM address
//  ram_wdata   out  DATA_W  registered RAM write data
//  ram_we      out  1       registered RAM write enable
//  ram_rdata   in   DATA_W  RAM output; valid 1 cycle after the address is sampled
// BEHAVIOUR
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. Always 3 cycles per access; no bypass.
//  IDLE
//   - arbitrate on the edge ending the cycle; latch owner, addr, we, wdata
//   - no request pending: stay in IDLE
//  ACCESS
//   - ram_addr/ram_wdata driven from latches
//   - ram_we = 1 only for a CPU write
//   - RAM samples at the end of this cycle
//  RESP
//   - ram_we = 0
//   - owner's ack/valid = 1
//   - owner's rdata = ram_rdata (combinational pass-through)
//   - CPU write: cpu_ack still pulses; cpu_rdata is don't-care
//  Latency: request sampled in IDLE at cycle 0 -> ack/valid in cycle 2.
//   Requester may drop or change its request at the edge ending the ack
//   cycle; the next IDLE samples the updated value.
//  Arbitration:
//   - disp wins, unless wait_cnt == MAX_WAIT and cpu_req=1, then CPU wins
//   - wait_cnt increments on each display grant while cpu_req=1
//   - wait_cnt clears on CPU grant, or on any IDLE cycle with cpu_req=0
//   - wait_cnt saturates at MAX_WAIT
//  Outputs at reset and when not owner:
//   - ram_we=0, cpu_ack=0, disp_valid=0, rdata outputs 0
//   - ram_addr holds its last value (0 after reset)
//  Reset (async, active-low):
//   - state=IDLE, wait_cnt=0, all outputs 0; ram_we drops immediately
//   - reset mid-access: the access is abandoned, no ack is issued; the
//     requester re-issues after reset release
// CONFIGURATION
//  ARB_STATS_EN defined:
//   - adds port cpu_wait_cnt  out  16
//   - counts cycles with cpu_req=1 where the CPU neither wins arbitration
//     nor owns the in-flight access
//   - saturates at 16'hFFFF; cleared only by reset
//  ARB_STATS_EN undefined: port and counter absent; arbitration identical.
// TESTING
//  1 RAM[0x0010]=0xDEADBEEF; CPU read 0x0010 at cycle 0 -> cpu_ack=1,
//    cpu_rdata=0xDEADBEEF in cycle 2 only.
//  2 CPU write 0x0020<=0x12345678 -> ram_we=1 in cycle 1 only, ram_addr=0x0020;
//    cpu_ack in cycle 2; read-back returns 0x12345678.
//  3 cpu_req and disp_req both single requests at cycle 0 -> disp_valid cycle 2,
//    cpu_ack cycle 5.
//  4 Both held continuously, MAX_WAIT=4 -> grant order D D D D C D D D D C,
//    one grant every 3 cycles.
//  5 reset low during ACCESS of a CPU write -> ram_we=0 same cycle, no cpu_ack;
//    FSM in IDLE on release.
//  6 ARB_STATS_EN, scenario 3 -> cpu_wait_cnt=3 after CPU grant; reset -> 0.

Source files
------------

// File: rtl/image_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// image_ram_arbiter_if
// Bundles the CPU data port, the display scanout read port and the image RAM
// port that meet at image_ram_arbiter.
//   slave  modport : the arbiter's view (takes requests, drives the RAM)
//   master modport : the surroundings' view (CPU, display engine, RAM)
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata                   CPU completion pulse and read data
//   disp_req/disp_addr                  display read request, held until disp_valid
//   disp_valid/disp_rdata               display completion pulse and read data
//   ram_addr/ram_wdata/ram_we           registered RAM controls
//   ram_rdata                           RAM output, one cycle after address
// ---------------------------------------------------------------------------
interface image_ram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  disp_req, disp_addr,
        input  ram_rdata,
        output cpu_ack, cpu_rdata,
        output disp_valid, disp_rdata,
        output ram_addr, ram_wdata, ram_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output disp_req, disp_addr,
        output ram_rdata,
        input  cpu_ack, cpu_rdata,
        input  disp_valid, disp_rdata,
        input  ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/image_ram_arbiter.sv
// ---------------------------------------------------------------------------
// image_ram_arbiter
// Shares one single-port synchronous image RAM between the CPU data port
// (read/write) and the display scanout engine (read-only). Display has
// priority; a wait counter lets the CPU in after MAX_WAIT consecutive display
// grants. One access is in flight at a time, always IDLE -> ACCESS -> RESP.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low
//   bus           image_ram_arbiter_if.slave (CPU, display and RAM signals)
//   cpu_wait_cnt  (only with ARB_STATS_EN) saturating count of cycles the
//                 CPU was requesting but neither won nor owned the access
// Optional feature macro: ARB_STATS_EN
// ---------------------------------------------------------------------------
module image_ram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    image_ram_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]          cpu_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    state_t            state_reg;
    logic              owner_cpu_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic              ram_we_reg;
    logic              cpu_ack_reg;
    logic              disp_valid_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;

    logic wait_full;
    logic cpu_wins;
    logic disp_wins;

    assign wait_full = (wait_cnt_reg == WAIT_W'(MAX_WAIT));
    // Display wins any contested IDLE cycle unless the CPU has already been
    // passed over MAX_WAIT times in a row.
    assign cpu_wins  = bus.cpu_req && (!bus.disp_req || wait_full);
    assign disp_wins = bus.disp_req && !cpu_wins;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            owner_cpu_reg  <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
            ram_we_reg     <= 1'b0;
            cpu_ack_reg    <= 1'b0;
            disp_valid_reg <= 1'b0;
            wait_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_wins) begin
                        owner_cpu_reg <= 1'b1;
                        ram_addr_reg  <= bus.cpu_addr;
                        ram_wdata_reg <= bus.cpu_wdata;
                        ram_we_reg    <= bus.cpu_we;
                        state_reg     <= ACCESS;
                    end else if (disp_wins) begin
                        owner_cpu_reg <= 1'b0;
                        ram_addr_reg  <= bus.disp_addr;
                        ram_we_reg    <= 1'b0;
                        state_reg     <= ACCESS;
                    end
                    // Counter tracks consecutive display grants that made a
                    // pending CPU wait; any idle moment without a CPU request
                    // or a CPU grant starts the count over.
                    if (!bus.cpu_req || cpu_wins) begin
                        wait_cnt_reg <= '0;
                    end else if (disp_wins && !wait_full) begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                ACCESS: begin
                    ram_we_reg     <= 1'b0;
                    cpu_ack_reg    <= owner_cpu_reg;
                    disp_valid_reg <= !owner_cpu_reg;
                    state_reg      <= RESP;
                end
                RESP: begin
                    cpu_ack_reg    <= 1'b0;
                    disp_valid_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: begin
                    ram_we_reg     <= 1'b0;
                    cpu_ack_reg    <= 1'b0;
                    disp_valid_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_addr   = ram_addr_reg;
    assign bus.ram_wdata  = ram_wdata_reg;
    assign bus.ram_we     = ram_we_reg;
    assign bus.cpu_ack    = cpu_ack_reg;
    assign bus.disp_valid = disp_valid_reg;
    // RAM data is passed straight through during the owner's response cycle
    // and forced to zero otherwise.
    assign bus.cpu_rdata  = cpu_ack_reg    ? bus.ram_rdata : '0;
    assign bus.disp_rdata = disp_valid_reg ? bus.ram_rdata : '0;

`ifdef ARB_STATS_EN
    logic [15:0] stats_reg;
    logic        cpu_blocked;

    // In IDLE the CPU is blocked if it loses arbitration; in ACCESS/RESP it is
    // blocked if the display owns the access in flight.
    assign cpu_blocked = bus.cpu_req &&
                         ((state_reg == IDLE) ? !cpu_wins : !owner_cpu_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stats_reg <= '0;
        end else if (cpu_blocked && (stats_reg != 16'hFFFF)) begin
            stats_reg <= stats_reg + 16'd1;
        end
    end

    assign cpu_wait_cnt = stats_reg;
`endif

endmodule

// File: tb/tb_image_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_image_ram_arbiter
// Directed bench for image_ram_arbiter: a behavioural synchronous RAM hangs
// off the RAM side; CPU and display requests are driven cycle by cycle and
// outputs are compared against hand-derived cycle-exact expectations.
// Build with ARB_STATS_EN defined to also cover cpu_wait_cnt.
// ---------------------------------------------------------------------------
module tb_image_ram_arbiter;

    logic clk;
    logic reset;

    image_ram_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

`ifdef ARB_STATS_EN
    logic [15:0] cpu_wait_cnt;
`endif

    image_ram_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .MAX_WAIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef ARB_STATS_EN
        ,
        .cpu_wait_cnt(cpu_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM with a bench-side preload port.
    logic [31:0] mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int n_cmp;
    int n_err;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated CPU transaction; starts at the beginning of cycle 0.
    task automatic cpu_txn(input logic we, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("cpu_ack", bus.cpu_ack, (c == 2));
            check_val("ram_we", bus.ram_we, (we && c == 1));
            if (c == 1) begin
                check_val("ram_addr", bus.ram_addr, addr);
                if (we) check_val("ram_wdata", bus.ram_wdata, wdata);
            end
            if (c == 2 && !we) check_val("cpu_rdata", bus.cpu_rdata, exp_rdata);
            next_cycle();
        end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check_val("cpu_ack_after", bus.cpu_ack, 1'b0);
        check_val("cpu_rdata_after", bus.cpu_rdata, 32'h0);
        $display("txn cpu %s addr=%04h data=%08h", we ? "write" : "read ",
                 addr, we ? wdata : exp_rdata);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;

        // Preload RAM while the arbiter is held in reset.
        next_cycle();
        pre_we   = 1'b1;
        pre_addr = 16'h0010;
        pre_data = 32'hDEADBEEF;
        next_cycle();
        pre_we = 1'b0;

        @(negedge clk);
        check_val("rst_ram_we", bus.ram_we, 1'b0);
        check_val("rst_cpu_ack", bus.cpu_ack, 1'b0);
        check_val("rst_disp_valid", bus.disp_valid, 1'b0);
        check_val("rst_ram_addr", bus.ram_addr, 16'h0);
        check_val("rst_ram_wdata", bus.ram_wdata, 32'h0);
        check_val("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check_val("rst_disp_rdata", bus.disp_rdata, 32'h0);
`ifdef ARB_STATS_EN
        check_val("rst_wait_cnt", cpu_wait_cnt, 16'h0);
`endif
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // 1: CPU read of preloaded word.
        cpu_txn(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF);
        // 2: CPU write then read-back.
        cpu_txn(1'b1, 16'h0020, 32'h12345678, 32'h0);
        cpu_txn(1'b0, 16'h0020, 32'h0, 32'h12345678);

        // 3: simultaneous single requests: display first, CPU three cycles later.
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0020;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 16'h0010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_val("t3_disp_valid", bus.disp_valid, (c == 2));
            check_val("t3_cpu_ack", bus.cpu_ack, (c == 5));
            if (c == 2) check_val("t3_disp_rdata", bus.disp_rdata, 32'hDEADBEEF);
            if (c == 5) begin
                check_val("t3_cpu_rdata", bus.cpu_rdata, 32'h12345678);
`ifdef ARB_STATS_EN
                check_val("t3_wait_cnt", cpu_wait_cnt, 16'd3);
`endif
            end
            next_cycle();
            if (c == 2) bus.disp_req = 1'b0;
        end
        bus.cpu_req = 1'b0;
        $display("txn contention: disp at cycle 2, cpu at cycle 5");
        next_cycle();

        // 4: both held: grants D D D D C D D D D C, one every 3 cycles.
        bus.cpu_req  = 1'b1;
        bus.disp_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
            int  k;
            logic resp;
            logic cpu_turn;
            k        = c / 3;
            resp     = (c % 3 == 2);
            cpu_turn = (k % 5 == 4);
            @(negedge clk);
            check_val("t4_disp_valid", bus.disp_valid, resp && !cpu_turn);
            check_val("t4_cpu_ack", bus.cpu_ack, resp && cpu_turn);
            if (resp && cpu_turn)  check_val("t4_cpu_rdata", bus.cpu_rdata, 32'h12345678);
            if (resp && !cpu_turn) check_val("t4_disp_rdata", bus.disp_rdata, 32'hDEADBEEF);
            if (resp) $display("txn grant %0d -> %s", k, cpu_turn ? "cpu" : "disp");
            next_cycle();
        end
        bus.cpu_req  = 1'b0;
        bus.disp_req = 1'b0;
        next_cycle();
        next_cycle();

        // 5: reset asserted during ACCESS of a CPU write.
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 16'h0030;
        bus.cpu_wdata = 32'hCAFEF00D;
        next_cycle();
        check_val("t5_we_in_access", bus.ram_we, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_val("t5_we_dropped", bus.ram_we, 1'b0);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        @(negedge clk);
        check_val("t5_no_ack_a", bus.cpu_ack, 1'b0);
        next_cycle();
        @(negedge clk);
        check_val("t5_no_ack_b", bus.cpu_ack, 1'b0);
`ifdef ARB_STATS_EN
        check_val("t5_wait_cnt", cpu_wait_cnt, 16'h0);
`endif
        next_cycle();
        reset = 1'b1;
        $display("txn reset during cpu write access");
        next_cycle();
        // FSM must be back in IDLE: a fresh read completes with normal latency.
        cpu_txn(1'b0, 16'h0020, 32'h0, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
